// File: rtl/arb_mux.sv
// arb_mux: N-channel valid/ready multiplexer with a single registered output
// stage. Each cycle at most one input channel is granted, either the channel
// named by sel (fixed mode) or the next valid channel after the last
// round-robin winner (round-robin mode).
//
// Optional build macro: ARB_MUX_ASSERT_EN compiles in the protocol checker
// arb_mux_chk. Without it no assertion code exists and behaviour is identical.

`ifdef ARB_MUX_ASSERT_EN
// Protocol checker: watches the arbiter ports and flags any rule violation.
module arb_mux_chk #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = $clog2(N)
) (
    input logic            clk_i,
    input logic            rst_i,
    input logic [N*W-1:0]  in_i,
    input logic [N-1:0]    in_valid_i,
    input logic [N-1:0]    in_ready_i,
    input logic [W-1:0]    out_i,
    input logic            out_valid_i,
    input logic            out_ready_i,
    input logic [CW-1:0]   out_ch_i
);

    logic [W-1:0] gnt_data_s;
    logic [W-1:0] exp_data_q;
    logic [CW-1:0] exp_ch_q;
    logic         gnt_q;

    // Pick out the data word of whichever channel is being granted now.
    always_comb begin
        gnt_data_s = '0;
        for (int i = 0; i < N; i++) begin
            if (in_ready_i[i]) begin
                gnt_data_s = in_i[i*W +: W];
            end else begin
                gnt_data_s = gnt_data_s;
            end
        end
    end

    // Remember the granted word so the next cycle's output can be compared.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_q      <= 1'b0;
            exp_data_q <= '0;
            exp_ch_q   <= '0;
        end else begin
            gnt_q      <= |in_ready_i;
            exp_data_q <= gnt_data_s;
            exp_ch_q   <= out_ch_i;
        end
    end

    a_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(in_ready_i))
        else $error("arb_mux_chk: ready_onehot0 check failed");

    a_ready_needs_valid: assert property (@(posedge clk_i) disable iff (rst_i)
        ((in_ready_i & ~in_valid_i) == '0))
        else $error("arb_mux_chk: ready_implies_valid check failed");

    a_hold_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (out_valid_i && !out_ready_i) |=>
            ($stable(out_i) && $stable(out_ch_i) && out_valid_i))
        else $error("arb_mux_chk: backpressure_stable check failed");

    a_grant_data: assert property (@(posedge clk_i) disable iff (rst_i)
        gnt_q |-> (out_valid_i && (out_i == exp_data_q)))
        else $error("arb_mux_chk: grant_data check failed");

endmodule
`endif

module arb_mux #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N*W-1:0]  in_i,
    input  logic [N-1:0]    in_valid_i,
    output logic [N-1:0]    in_ready_o,
    input  logic [CW-1:0]   sel_i,
    input  logic            mode_i,
    output logic [W-1:0]    out_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [CW-1:0]   out_ch_o
);

    // N held in CW+1 bits so an out-of-range sel can be detected for any N.
    localparam logic [CW:0]   N_EXT   = N[CW:0];
    // After reset the pointer sits on the last channel so channel 0 wins first.
    localparam logic [CW-1:0] PTR_RST = CW'(N - 1);

    logic [W-1:0]  out_q,       out_d;
    logic [CW-1:0] out_ch_q,    out_ch_d;
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] ptr_q,       ptr_d;

    logic          ld_s;
    logic          gnt_vld_s;
    logic [CW-1:0] gnt_idx_s;
    logic [N-1:0]  gnt_vec_s;
    logic [W-1:0]  gnt_data_s;

    // Grant decision: at most one channel, only when the output stage can load.
    always_comb begin
        int            cand;
        logic [CW-1:0] cand_idx;
        ld_s      = !out_valid_q || out_ready_i;
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
        cand      = 0;
        cand_idx  = '0;
        if (!rst_i && ld_s) begin
            if (!mode_i) begin
                // Fixed mode: only the selected channel may win; sel >= N never does.
                if (({1'b0, sel_i} < N_EXT) && in_valid_i[sel_i]) begin
                    gnt_vld_s = 1'b1;
                    gnt_idx_s = sel_i;
                end else begin
                    gnt_vld_s = 1'b0;
                end
            end else begin
                // Round-robin: scan upward from ptr+1, wrapping, first valid wins.
                for (int k = 1; k <= N; k++) begin
                    cand     = (int'(ptr_q) + k) % N;
                    cand_idx = CW'(cand);
                    if (!gnt_vld_s && in_valid_i[cand_idx]) begin
                        gnt_vld_s = 1'b1;
                        gnt_idx_s = cand_idx;
                    end else begin
                        gnt_vld_s = gnt_vld_s;
                    end
                end
            end
        end else begin
            gnt_vld_s = 1'b0;
        end
    end

    // One-hot ready vector and the granted channel's data word.
    always_comb begin
        gnt_vec_s  = '0;
        gnt_data_s = in_i[gnt_idx_s*W +: W];
        if (gnt_vld_s) begin
            gnt_vec_s[gnt_idx_s] = 1'b1;
        end else begin
            gnt_vec_s = '0;
        end
    end

    assign in_ready_o = gnt_vec_s;

    // Next-state of the output stage and round-robin pointer.
    always_comb begin
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (gnt_vld_s) begin
            // Load a new word; a simultaneous drain needs no extra handling.
            out_d       = gnt_data_s;
            out_ch_d    = gnt_idx_s;
            out_valid_d = 1'b1;
            if (mode_i) begin
                ptr_d = gnt_idx_s;
            end else begin
                ptr_d = ptr_q;
            end
        end else if (ld_s) begin
            // Drained (or already empty) with nothing to load: go empty, keep data.
            out_valid_d = 1'b0;
        end else begin
            // Backpressure: everything holds.
            out_valid_d = out_valid_q;
        end
    end

    // Output register stage and pointer, with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q       <= {W{1'b0}};
            out_ch_q    <= {CW{1'b0}};
            out_valid_q <= 1'b0;
            ptr_q       <= PTR_RST;
        end else begin
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_o       = out_q;
    assign out_ch_o    = out_ch_q;
    assign out_valid_o = out_valid_q;

`ifdef ARB_MUX_ASSERT_EN
    arb_mux_chk #(.N(N), .W(W), .CW(CW)) u_chk (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_i        (in_i),
        .in_valid_i  (in_valid_i),
        .in_ready_i  (in_ready_o),
        .out_i       (out_q),
        .out_valid_i (out_valid_q),
        .out_ready_i (out_ready_i),
        .out_ch_i    (out_ch_q)
    );
`endif

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux (N=4, W=8): a driver applies stimulus and a
// behavioural model predicts grants; a monitor compares the output words.
module tb_arb_mux;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 2;

    logic            clk;
    logic            rst;
    logic [N*W-1:0]  din;
    logic [N-1:0]    vin;
    logic [N-1:0]    rdy;
    logic [CW-1:0]   sel;
    logic            mode;
    logic [W-1:0]    dout;
    logic            ovld;
    logic            ordy;
    logic [CW-1:0]   och;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [CW-1:0] ch;
    } word_t;

    word_t sbq[$];
    int    n_cmp   = 0;
    int    n_fail  = 0;
    int    m_ptr   = N - 1;
    bit    m_valid = 1'b0;
    int    dut_g   = -1;

    arb_mux #(.N(N), .W(W), .CW(CW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_i        (din),
        .in_valid_i  (vin),
        .in_ready_o  (rdy),
        .sel_i       (sel),
        .mode_i      (mode),
        .out_o       (dout),
        .out_valid_o (ovld),
        .out_ready_i (ordy),
        .out_ch_o    (och)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference grant from the arbitration rules; -1 means no grant.
    function automatic int ref_grant(input bit r, input bit m, input int s,
                                     input logic [N-1:0] v, input bit ordy_v);
        if (r) return -1;
        if (m_valid && !ordy_v) return -1;
        if (!m) begin
            if (s < N && v[s]) return s;
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // One cycle: drive at the falling edge, check ready/valid, advance the model.
    task automatic step(input bit r, input bit m, input int s, input logic [N-1:0] v,
                        input logic [N*W-1:0] d, input bit ordy_v);
        int g;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        rst  = r;
        mode = m;
        sel  = s[CW-1:0];
        vin  = v;
        din  = d;
        ordy = ordy_v;
        #1;
        check("out_valid", {31'd0, ovld}, {31'd0, m_valid});
        g = ref_grant(r, m, s, v, ordy_v);
        exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        check("in_ready", {28'd0, rdy}, {28'd0, exp_rdy});
        dut_g = -1;
        for (int i = 0; i < N; i++) if (rdy[i]) dut_g = i;
        if (r) begin
            sbq.delete();
            m_valid = 1'b0;
            m_ptr   = N - 1;
        end else if (g >= 0) begin
            sbq.push_back({d[g*W +: W], CW'(g)});
            m_valid = 1'b1;
            if (m) m_ptr = g;
        end else if (!m_valid || ordy_v) begin
            m_valid = 1'b0;
        end
    endtask

    // Monitor: on a transfer pop and compare; while stalled the word must match the head.
    always @(negedge clk) begin
        word_t e;
        #3;
        if (!rst && ovld) begin
            if (sbq.size() == 0) begin
                check("sb_nonempty", 32'd0, 32'd1);
            end else begin
                e = ordy ? sbq.pop_front() : sbq[0];
                check(ordy ? "out_data" : "hold_data", {24'd0, dout}, {24'd0, e.d});
                check(ordy ? "out_ch" : "hold_ch", {30'd0, och}, {30'd0, e.ch});
            end
        end
    end

    initial begin
        int rr_exp[6];
        rr_exp = '{0, 1, 3, 0, 1, 3};
        rst = 1'b1; mode = 1'b1; sel = '0; vin = 4'hF; din = '0; ordy = 1'b1;

        // Reset with all channels valid
        step(1'b1, 1'b1, 0, 4'hF, 32'h44332211, 1'b1);
        check("rst_out", {24'd0, dout}, 32'd0);
        check("rst_out_ch", {30'd0, och}, 32'd0);
        step(1'b1, 1'b1, 0, 4'hF, 32'h44332211, 1'b1);

        // Round-robin over 1011: channel 2 is skipped
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 0, 4'b1011, 32'h44332211, 1'b1);
            check("rr_seq", dut_g, rr_exp[i]);
        end

        // Fixed mode sel=2
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2, 4'hF, 32'h44332211, 1'b1);

        // Backpressure on A5 from channel 1, then drain with a same-cycle reload
        step(1'b0, 1'b0, 1, 4'b0010, 32'h0000A500, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1, 4'b0010, 32'h00005A00, 1'b0);
        step(1'b0, 1'b0, 1, 4'b0010, 32'h00005A00, 1'b1);
        check("no_bubble_grant", dut_g, 1);

        // Fixed sel=1 with only channel 0 valid: nothing granted, output empties
        step(1'b0, 1'b0, 1, 4'b0001, 32'h000000C3, 1'b1);
        step(1'b0, 1'b0, 1, 4'b0001, 32'h000000C3, 1'b1);

        // Round-robin wrap from ptr=3 to channel 0
        step(1'b0, 1'b1, 0, 4'b1000, 32'h77000000, 1'b1);
        step(1'b0, 1'b1, 0, 4'b0001, 32'h00000066, 1'b1);
        check("rr_wrap", dut_g, 0);

        // Hold a word, switch mode, then reset during a transfer
        step(1'b0, 1'b1, 0, 4'b0010, 32'h0000BB00, 1'b1);
        step(1'b0, 1'b1, 0, 4'hF, 32'h11223344, 1'b0);
        step(1'b0, 1'b0, 0, 4'hF, 32'h11223344, 1'b0);
        step(1'b1, 1'b0, 0, 4'hF, 32'h11223344, 1'b1);
        step(1'b0, 1'b1, 0, 4'hF, 32'h11223344, 1'b1);
        check("post_rst_first", dut_g, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), 4'($urandom), $urandom,
                 ($urandom_range(0, 3) != 0));
        end

        // Drain
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 0, 4'h0, 32'h0, 1'b1);
        check("sb_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter: N, default 4, number of input channels (2..16).
REQ-002 Parameter: W, default 8, data width per channel.
REQ-003 Parameter: CW, default $clog2(N), channel-index width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
REQ-007 in_valid  input  N  per-channel data-valid.
REQ-008 in_ready  output  N  per-channel accept; transfer on channel i when in_valid[i] && in_ready[i].
REQ-009 sel  input  CW  channel select, used in fixed mode only.
REQ-010 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-011 out  output  W  registered selected data.
REQ-012 out_valid  output  1  out holds an unconsumed word.
REQ-013 out_ready  input  1  downstream accept; transfer when out_valid && out_ready.
REQ-014 out_ch  output  CW  channel index of the word in out.

Function
REQ-015 Single output register stage; input-to-output latency exactly 1 cycle.
REQ-016 Load enable ld = !out_valid || out_ready; no channel is granted when ld is 0.
REQ-017 Fixed mode: grant channel sel iff in_valid[sel] and ld; sel >= N grants nothing.
REQ-018 Round-robin mode: grant the first valid channel searching upward from ptr+1 modulo N, wrapping N-1 -> 0.
REQ-019 ptr (CW bits) updates to the granted index only on a round-robin-mode transfer; it holds in fixed mode.
REQ-020 in_ready SHALL be one-hot or zero every cycle and equal the grant vector; it is combinational from in_valid, sel, mode, ptr, out_valid, out_ready.
REQ-021 On grant: out <= granted channel data, out_ch <= granted index, out_valid <= 1.
REQ-022 ld = 1 with no grant: out_valid <= 0; out and out_ch hold their last values.
REQ-023 While out_valid && !out_ready: out, out_ch, out_valid SHALL hold stable.
REQ-024 Simultaneous drain and grant in the same cycle: new word loads, out_valid stays 1, no bubble; full throughput of one word per cycle.
REQ-025 Mode or sel change takes effect on the next grant decision; a word already in out is unaffected.
REQ-026 No valid inputs: no grant, ptr unchanged.

Reset
REQ-027 While rst is high at a clk edge: out_valid <= 0, out <= 0, out_ch <= 0, ptr <= N-1 (channel 0 has first round-robin priority).
REQ-028 in_ready SHALL be all-zero during any cycle rst is high.
REQ-029 Reset mid-operation discards the held word; no transfer is reported on the reset cycle.

Configuration
REQ-030 Macro ARB_MUX_ASSERT_EN: when defined, concurrent assertions are compiled in, disabled iff rst.
REQ-031 With ARB_MUX_ASSERT_EN: assertions check in_ready one-hot-or-zero, in_ready implies in_valid, out/out_ch/out_valid stable under backpressure, out equals channel out_ch data of the previous cycle after a grant; each failure prints a message naming the check.
REQ-032 Without ARB_MUX_ASSERT_EN: no assertion code is compiled; functional behaviour is identical.

Verification (N=4, W=8)
REQ-033 Reset: rst=1 for 2 cycles with in_valid=4'hF -> in_ready=0, out_valid=0, out=0; first RR grant after release is channel 0.
REQ-034 Fixed mode: mode=0, sel=2, in=32'h44332211, in_valid=4'hF, out_ready=1 -> in_ready=4'b0100 every cycle, out=8'h33, out_ch=2 from the next cycle.
REQ-035 Round-robin: mode=1, in_valid=4'b1011 held, out_ready=1 -> grant sequence 0,1,3,0,1,3; channel 2 never granted.
REQ-036 Backpressure: word 8'hA5 from channel 1 loaded, out_ready=0 for 3 cycles -> in_ready=0, out=8'hA5, out_ch=1 stable; on out_ready=1 next word loads same cycle with no bubble.
REQ-037 Boundaries: fixed mode sel=1, in_valid=4'b0001 -> no grant, out_valid falls to 0 after drain; RR with ptr=3 and in_valid=4'b0001 -> wrap grant to channel 0.
REQ-038 Mid-operation: switch mode 1->0 with a word held, then assert rst during a transfer -> held word unchanged until drained; reset cycle reports no transfer and ptr returns to 3.
